regfile_32: RTL and testbench
=============================

# regfile_32

Register file of the single-cycle MIPS datapath: 32 general-purpose 32-bit registers with two combinational read ports and one clocked write port. Read port B drives the `rt` operand of the shift unit (and ALU B input); read port A drives `rs`. Writeback (ALU, shifter or memory result) enters through the write port at the end of each instruction cycle. Register $0 is hardwired to zero.

## Interface
Parameters:
- `WIDTH`, 32, data width of each register
- `DEPTH`, 32, number of registers (power of two)
- `AW`, 5, address width, log2(`DEPTH`)

Ports:
- `clk`  input  1  clock; all writes occur on the rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `ra_addr`  input  `AW`  read port A address (rs)
- `rb_addr`  input  `AW`  read port B address (rt)
- `ra_data`  output  `WIDTH`  read port A data
- `rb_data`  output  `WIDTH`  read port B data
- `we`  input  1  write enable
- `wr_addr`  input  `AW`  write address (rd or rt)
- `wr_data`  input  `WIDTH`  write data

## Operation
- Storage: `DEPTH` registers r[0..DEPTH-1], each `WIDTH` bits.
- Reset: `rst_n` low clears r[1..DEPTH-1] to 0 immediately, independent of `clk`. While `rst_n` is low, writes are ignored and both read ports return 0 for every address.
- Write: on the rising edge of `clk` with `rst_n` high, `we`=1 and `wr_addr`≠0, r[wr_addr] ← `wr_data`. A write to address 0 is discarded. With `we`=0, no register changes.
- Read: `ra_data` = r[ra_addr] and `rb_data` = r[rb_addr], combinational. Address 0 always reads 0.
- Both ports may read the same address in the same cycle; each port returns the same value.
- Reads and writes are independent: a read of a different address is unaffected by a concurrent write.
- Same-address read/write in one cycle: behaviour is set by `REGFILE_BYPASS_EN` (see Configuration).
- X/Z on `wr_addr` with `we`=0 has no effect. With `we`=1, such a write is a protocol violation and its result is undefined.

## Timing
- Read latency: 0 cycles (combinational from address to data).
- Write latency: 1 edge. The value is visible on the read ports after the rising edge that samples `we`=1.
- Reset assertion mid-cycle: outputs go to 0 without waiting for a clock edge. Any write pending at that edge is lost.
- Reset release: the first write takes effect on the first rising edge at which `rst_n` is high.
- Reset values of the outputs: `ra_data`=0 and `rb_data`=0.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - Write-through forwarding. If `we`=1, `wr_addr`≠0 and a read address equals `wr_addr`, that port returns `wr_data` in the same cycle, before the edge.
  - Used when a pipelined variant needs same-cycle forwarding.
- `REGFILE_BYPASS_EN` undefined:
  - The port returns the stored (old) value until the edge.
  - This is the single-cycle default.
- In both modes, address 0 returns 0 and writes to address 0 are discarded.

## Structure
- Shared package `mips_pkg` holds:
  - `REG_WIDTH`=32, `REG_COUNT`=32, `REG_AW`=5
  - `REG_ZERO`=5'd0
  - typedef `reg_addr_t` (5-bit) and `word_t` (32-bit); the shifter and ALU use the same types.
- Sub-module `reg_32`: one 32-bit register with asynchronous active-low clear and load enable. Instantiate it 31 times (r[1..31]). r[0] is a constant 0, not a flop.
- Write-enable decode (5→32 one-hot, gated by `we`) and the two 32:1 read muxes are in the top level.

## Test plan
- Reset: pulse `rst_n` low mid-cycle after writing r[5]=32'hDEADBEEF → `ra_data`/`rb_data` return 0 immediately. After release, r[5] reads 0.
- Basic write/read: write r[9]=32'h8000_0001. Next cycle `ra_addr`=9, `rb_addr`=9 → both read 32'h8000_0001. r[10] is still 0.
- $0 protection: `we`=1, `wr_addr`=0, `wr_data`=32'hFFFF_FFFF → `ra_addr`=0 reads 0 after the edge.
- Write disabled: `we`=0, `wr_addr`=3, `wr_data`=32'h1234_5678 → r[3] keeps its prior value 32'hCAFE_0000.
- Same-cycle read/write of r[7] (old 32'h1, new 32'h2):
  - Before the edge, `rb_data`=32'h2 with `REGFILE_BYPASS_EN` and 32'h1 without it.
  - After the edge, 32'h2 in both modes.
- Shifter feed: r[4]=32'hF000_000F, `rb_addr`=4 into srl with shamt=4 → shifter output 32'h0F00_0000.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath widths, register-file constants and operand types
package mips_pkg;

    localparam int REG_WIDTH = 32;
    localparam int REG_COUNT = 32;
    localparam int REG_AW    = 5;

    typedef logic [REG_AW-1:0]    reg_addr_t;
    typedef logic [REG_WIDTH-1:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

    // True when an address names the hardwired-zero register
    function automatic logic is_zero_reg(input reg_addr_t addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/reg_32.sv
// rtl/reg_32.sv - single general-purpose register with async active-low clear and load enable
module reg_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear immediately on reset; otherwise capture d when selected by the write decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_32.sv
// rtl/regfile_32.sv - 32x32 MIPS register file, two comb read ports, one write port; option macro REGFILE_BYPASS_EN
import mips_pkg::*;

module regfile_32 #(
    parameter int WIDTH = REG_WIDTH,
    parameter int DEPTH = REG_COUNT,
    parameter int AW    = REG_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra_addr,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] ra_data,
    output logic [WIDTH-1:0] rb_data,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data
);

    // Index 0 is a constant zero; indices 1..DEPTH-1 come from real flops
    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:1] wr_sel;
    logic [WIDTH-1:0] ra_sel;
    logic [WIDTH-1:0] rb_sel;

    assign regs[0] = '0;

    // One-hot write decode; there is no select line for r0, so writes there vanish
    always_comb begin
        wr_sel = '0;
        if (we) begin
            for (int k = 1; k < DEPTH; k++) begin
                wr_sel[k] = (wr_addr == AW'(k));
            end
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_reg
            reg_32 #(
                .WIDTH (WIDTH)
            ) u_reg (
                .clk   (clk),
                .rst_n (rst_n),
                .load  (wr_sel[gi]),
                .d     (wr_data),
                .q     (regs[gi])
            );
        end
    endgenerate

`ifdef REGFILE_BYPASS_EN
    logic wr_live;
    assign wr_live = we && (wr_addr != AW'(REG_ZERO));

    // Read muxes with write-through: a port addressing the live write target sees wr_data now
    always_comb begin
        ra_sel = regs[ra_addr];
        rb_sel = regs[rb_addr];
        if (wr_live && (ra_addr == wr_addr)) begin
            ra_sel = wr_data;
        end
        if (wr_live && (rb_addr == wr_addr)) begin
            rb_sel = wr_data;
        end
    end
`else
    // Read muxes return the stored value; a concurrent write shows up only after the edge
    always_comb begin
        ra_sel = regs[ra_addr];
        rb_sel = regs[rb_addr];
    end
`endif

    // Force zero while in reset so forwarded write data cannot leak out
    always_comb begin
        ra_data = rst_n ? ra_sel : '0;
        rb_data = rst_n ? rb_sel : '0;
    end

endmodule

// File: tb/tb_regfile_32.sv
// tb/tb_regfile_32.sv - self-checking bench for regfile_32 with a behavioural array model
module tb_regfile_32;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ra_addr;
    logic [4:0]  rb_addr;
    logic [31:0] ra_data;
    logic [31:0] rb_data;
    logic        we;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    logic [31:0] model [32];
    int          n_pass;
    int          n_total;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    regfile_32 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (ra_addr),
        .rb_addr (rb_addr),
        .ra_data (ra_data),
        .rb_data (rb_data),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (!rst_n) return 32'h0;
        if (BYPASS && we && wr_addr != 5'd0 && a == wr_addr) return wr_data;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // One instruction cycle: drive after the falling edge, check before and after the rising edge
    task automatic cycle(input string tag, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a, input logic [4:0] b);
        @(negedge clk);
        we = w; wr_addr = wa; wr_data = wd; ra_addr = a; rb_addr = b;
        #1;
        check({tag, "_pre_a"}, ra_data, exp_read(a));
        check({tag, "_pre_b"}, rb_data, exp_read(b));
        @(posedge clk);
        if (rst_n && w && wa != 5'd0) model[wa] = wd;
        #1;
        check({tag, "_post_a"}, ra_data, exp_read(a));
        check({tag, "_post_b"}, rb_data, exp_read(b));
    endtask

    initial begin
        logic [4:0]  wa, a, b;
        logic [31:0] wd;
        logic        w;

        n_pass = 0; n_total = 0;
        clear_model();
        rst_n = 1'b0; we = 1'b0; wr_addr = 5'd0; wr_data = 32'h0;
        ra_addr = 5'd1; rb_addr = 5'd31;
        #12;
        check("reset_ra", ra_data, 32'h0);
        check("reset_rb", rb_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read, neighbour untouched
        cycle("w9", 1'b1, 5'd9, 32'h8000_0001, 5'd9, 5'd10);
        cycle("r9", 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
        check("r9_both", rb_data, 32'h8000_0001);
        check("r10_zero", model[10] === 32'h0 ? ra_data : 32'hBAD0_BAD0, 32'h8000_0001);

        // $0 protection
        cycle("w0", 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        check("r0_zero", ra_data, 32'h0);

        // Write disabled keeps prior value
        cycle("w3", 1'b1, 5'd3, 32'hCAFE_0000, 5'd3, 5'd0);
        cycle("we0", 1'b0, 5'd3, 32'h1234_5678, 5'd3, 5'd3);
        check("r3_kept", ra_data, 32'hCAFE_0000);

        // Same-cycle read/write of r7
        cycle("w7a", 1'b1, 5'd7, 32'h1, 5'd0, 5'd0);
        @(negedge clk);
        we = 1'b1; wr_addr = 5'd7; wr_data = 32'h2; ra_addr = 5'd0; rb_addr = 5'd7;
        #1;
        check("r7_pre", rb_data, BYPASS ? 32'h2 : 32'h1);
        @(posedge clk);
        model[7] = 32'h2;
        #1;
        check("r7_post", rb_data, 32'h2);

        // Shifter feed: srl by 4 of port B
        cycle("w4", 1'b1, 5'd4, 32'hF000_000F, 5'd0, 5'd4);
        check("srl4", rb_data >> 4, 32'h0F00_0000);

        // Mid-cycle reset after r5 write, with a write pending at the next edge
        cycle("w5", 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5);
        @(negedge clk);
        we = 1'b1; wr_addr = 5'd5; wr_data = 32'h1111_2222; ra_addr = 5'd5; rb_addr = 5'd5;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ra", ra_data, 32'h0);
        check("rst_mid_rb", rb_data, 32'h0);
        clear_model();
        @(posedge clk);
        #1;
        check("rst_hold_ra", ra_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; we = 1'b0;
        #1;
        check("rst_rel_r5", ra_data, 32'h0);
        // First write after release lands on the first rising edge
        cycle("w6", 1'b1, 5'd6, 32'h0BAD_F00D, 5'd6, 5'd5);
        check("r6_first", ra_data, 32'h0BAD_F00D);

        // Randomised traffic against the array model
        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            a  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            b  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            cycle("rand", w, wa, wd, a, b);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
